// File: rtl/bht_gshare_predictor.sv
// rtl/bht_gshare_predictor.sv - tagged gshare branch history table with speculative GHR and sequenced clear
//
// Purpose: predicts conditional branch direction from a direct-mapped table of
// saturating counters indexed by PC XOR global history. Reads shift the GHR
// speculatively; resolved writes train the table and repair the GHR on a
// mispredict. A clear pulse walks the table one entry per cycle.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_bht_read_en/_pc         prediction request and branch PC
//   o_bht_taken_pre/_hit/_ghr registered prediction, tag hit, history snapshot used
//   i_bht_write_en/_pc/_taken resolved-branch update
//   i_bht_write_ghr           history snapshot returned with the prediction
//   i_bht_write_mispredict    requests GHR repair from the snapshot
//   i_bht_clear               pulse that starts a table clear
//   o_bht_busy                clear in progress
module bht_gshare_predictor #(
  parameter int CNT_WIDTH = 2,
  parameter int INDEXBIT  = 8,
  parameter int TAGBIT    = 20,
  parameter int HISTBIT   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_bht_read_en,
  input  logic [31:0]         i_bht_read_pc,
  output logic                o_bht_taken_pre,
  output logic                o_bht_hit,
  output logic [HISTBIT-1:0]  o_bht_ghr,
  input  logic                i_bht_write_en,
  input  logic [31:0]         i_bht_write_pc,
  input  logic                i_bht_write_taken,
  input  logic [HISTBIT-1:0]  i_bht_write_ghr,
  input  logic                i_bht_write_mispredict,
  input  logic                i_bht_clear,
  output logic                o_bht_busy
);

  localparam int ENTRIES = 2 ** INDEXBIT;
  localparam logic [CNT_WIDTH-1:0] CNT_RST = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [INDEXBIT-1:0]   ptr_q, ptr_d;
  logic [HISTBIT-1:0]    ghr_q, ghr_d;
  logic                  taken_q, taken_d;
  logic                  hit_q, hit_d;
  logic [HISTBIT-1:0]    ghr_out_q, ghr_out_d;
  logic                  busy_q, busy_d;

  logic                  valid_q [ENTRIES];
  logic                  valid_d [ENTRIES];
  logic [TAGBIT-1:0]     tag_q   [ENTRIES];
  logic [TAGBIT-1:0]     tag_d   [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_q   [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_d   [ENTRIES];

  logic [INDEXBIT-1:0]   rd_idx, wr_idx;
  logic [TAGBIT-1:0]     rd_tag, wr_tag;
  logic                  rd_hit, rd_taken, wr_hit;
  logic                  unused_bits;

  // Index hashing: history is zero-extended into the low index bits.
  assign rd_idx = i_bht_read_pc[INDEXBIT+1:2]  ^ INDEXBIT'(ghr_q);
  assign wr_idx = i_bht_write_pc[INDEXBIT+1:2] ^ INDEXBIT'(i_bht_write_ghr);
  assign rd_tag = i_bht_read_pc[TAGBIT+INDEXBIT+1:INDEXBIT+2];
  assign wr_tag = i_bht_write_pc[TAGBIT+INDEXBIT+1:INDEXBIT+2];

  // Table lookups see registered state only, so a same-cycle write is not bypassed.
  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken = rd_hit && cnt_q[rd_idx][CNT_WIDTH-1];
  assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign unused_bits = ^{i_bht_read_pc, i_bht_write_pc, i_bht_write_ghr};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    taken_d   = taken_q;
    hit_d     = hit_q;
    ghr_out_d = ghr_out_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;

    if (state_q == ST_IDLE) begin
      if (i_bht_read_en) begin
        taken_d   = rd_taken;
        hit_d     = rd_hit;
        ghr_out_d = ghr_q;
        ghr_d     = {ghr_q[HISTBIT-2:0], rd_taken};
      end
      if (i_bht_write_en) begin
        if (wr_hit) begin
          if (i_bht_write_taken && (cnt_q[wr_idx] != CNT_MAX)) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] + CNT_WIDTH'(1);
          end else if (!i_bht_write_taken && (cnt_q[wr_idx] != '0)) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] - CNT_WIDTH'(1);
          end
        end else begin
          valid_d[wr_idx] = 1'b1;
          tag_d[wr_idx]   = wr_tag;
          cnt_d[wr_idx]   = i_bht_write_taken ? CNT_WT : CNT_RST;
        end
        // Repair wins over the speculative shift: that read was wrong-path.
        if (i_bht_write_mispredict) begin
          ghr_d = {i_bht_write_ghr[HISTBIT-2:0], i_bht_write_taken};
        end
      end
      if (i_bht_clear) begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        ghr_d   = '0;
      end
    end else begin
      if (i_bht_read_en) begin
        taken_d   = 1'b0;
        hit_d     = 1'b0;
        ghr_out_d = '0;
      end
      valid_d[ptr_q] = 1'b0;
      cnt_d[ptr_q]   = CNT_RST;
      ptr_d          = ptr_q + INDEXBIT'(1);
      if (ptr_q == {INDEXBIT{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      ghr_q     <= '0;
      taken_q   <= 1'b0;
      hit_q     <= 1'b0;
      ghr_out_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_RST;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ghr_q     <= ghr_d;
      taken_q   <= taken_d;
      hit_q     <= hit_d;
      ghr_out_q <= ghr_out_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_bht_taken_pre = taken_q;
  assign o_bht_hit       = hit_q;
  assign o_bht_ghr       = ghr_out_q;
  assign o_bht_busy      = busy_q;

endmodule

// File: tb/tb_bht_gshare_predictor.sv
// tb/tb_bht_gshare_predictor.sv - directed self-checking bench for bht_gshare_predictor
module tb_bht_gshare_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_pc = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_pc = '0;
  logic        wr_taken = 1'b0;
  logic [3:0]  wr_ghr = '0;
  logic        wr_mis = 1'b0;
  logic        clr = 1'b0;

  logic       taken2, hit2, busy2;
  logic [3:0] ghr2;
  logic       taken3, hit3, busy3;
  logic [3:0] ghr3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bht_gshare_predictor #(.CNT_WIDTH(2), .INDEXBIT(4), .TAGBIT(8), .HISTBIT(4)) u_dut (
    .clk(clk), .rstn(rstn),
    .i_bht_read_en(rd_en), .i_bht_read_pc(rd_pc),
    .o_bht_taken_pre(taken2), .o_bht_hit(hit2), .o_bht_ghr(ghr2),
    .i_bht_write_en(wr_en), .i_bht_write_pc(wr_pc), .i_bht_write_taken(wr_taken),
    .i_bht_write_ghr(wr_ghr), .i_bht_write_mispredict(wr_mis),
    .i_bht_clear(clr), .o_bht_busy(busy2)
  );

  bht_gshare_predictor #(.CNT_WIDTH(3), .INDEXBIT(4), .TAGBIT(8), .HISTBIT(4)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .i_bht_read_en(rd_en), .i_bht_read_pc(rd_pc),
    .o_bht_taken_pre(taken3), .o_bht_hit(hit3), .o_bht_ghr(ghr3),
    .i_bht_write_en(wr_en), .i_bht_write_pc(wr_pc), .i_bht_write_taken(wr_taken),
    .i_bht_write_ghr(wr_ghr), .i_bht_write_mispredict(wr_mis),
    .i_bht_clear(clr), .o_bht_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    wr_mis = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] pc);
    rd_en = 1'b1;
    rd_pc = pc;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic m);
    wr_en    = 1'b1;
    wr_pc    = pc;
    wr_ghr   = g;
    wr_taken = t;
    wr_mis   = m;
  endtask

  task automatic chk_pred(input string tag, input logic h, input logic t, input logic [3:0] g);
    chk({tag, "_hit"}, {31'd0, hit2}, {31'd0, h});
    chk({tag, "_taken"}, {31'd0, taken2}, {31'd0, t});
    chk({tag, "_ghr"}, {28'd0, ghr2}, {28'd0, g});
  endtask

  int busy_cycles;
  logic sat_t [17];
  logic sat_e [17];

  initial begin
    // Reset state
    #12;
    chk_pred("reset", 1'b0, 1'b0, 4'h0);
    chk("reset_busy", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #6;

    // Allocate / train: pc 0x40 maps to index 0 with GHR 0
    rd(32'h40);                   step(); chk_pred("alloc_first_read", 1'b0, 1'b0, 4'h0);
    wr(32'h40, 4'h0, 1'b1, 1'b0); step();
    wr(32'h40, 4'h0, 1'b1, 1'b0); step();
    wr(32'h40, 4'h0, 1'b1, 1'b0); step(); chk_pred("hold_after_writes", 1'b0, 1'b0, 4'h0);
    rd(32'h40);                   step(); chk_pred("trained_read", 1'b1, 1'b1, 4'h0);
    // GHR is now 0001 so pc 0x40 indexes entry 1, which is empty
    rd(32'h40);                   step(); chk_pred("ghr_shift_read", 1'b0, 1'b0, 4'h1);
    // GHR now 0010

    // Mispredict repair
    wr(32'h0, 4'h7, 1'b1, 1'b0);  step();     // entry 7 <- tag 0, counter 2
    wr(32'h3C, 4'h2, 1'b1, 1'b1); step();     // GHR <- 0101
    rd(32'h0); wr(32'h0, 4'h3, 1'b1, 1'b1); step();
    chk_pred("mispredict_same_cycle_read", 1'b0, 1'b0, 4'h5);
    rd(32'h0);                    step(); chk_pred("after_repair_read_idx7", 1'b1, 1'b1, 4'h7);

    // Tag conflict at index 0
    wr(32'h3C, 4'h0, 1'b0, 1'b1); step();     // GHR <- 0
    wr(32'h440, 4'h0, 1'b1, 1'b0); step();
    rd(32'h440); wr(32'h3C, 4'h0, 1'b0, 1'b1); step();
    chk_pred("conflict_new_owner", 1'b1, 1'b1, 4'h0);
    rd(32'h40);                   step(); chk_pred("conflict_evicted", 1'b0, 1'b0, 4'h0);

    // Same-cycle read/write, no bypass
    wr(32'h8, 4'h0, 1'b0, 1'b0);  step();     // entry 2 counter 1
    rd(32'h8); wr(32'h8, 4'h0, 1'b1, 1'b0); step();
    chk_pred("same_cycle_prewrite", 1'b1, 1'b0, 4'h0);
    rd(32'h8);                    step(); chk_pred("next_cycle_postwrite", 1'b1, 1'b1, 4'h0);
    // GHR now 0001

    // Clear
    clr = 1'b1; step();
    chk("clear_busy_rise", {31'd0, busy2}, 32'd1);
    busy_cycles = 0;
    while (busy2 && busy_cycles < 40) begin
      busy_cycles++;
      if (busy_cycles == 3) rd(32'h8);
      if (busy_cycles == 5) clr = 1'b1;
      if (busy_cycles == 7) wr(32'h8, 4'h7, 1'b1, 1'b1);
      step();
      if (busy_cycles == 3) chk_pred("read_during_clear", 1'b0, 1'b0, 4'h0);
    end
    chk("busy_cycle_count", busy_cycles, 32'd16);
    rd(32'h440); step(); chk_pred("post_clear_0x440", 1'b0, 1'b0, 4'h0);
    rd(32'h8);   step(); chk_pred("post_clear_0x8", 1'b0, 1'b0, 4'h0);
    rd(32'h0);   step(); chk_pred("post_clear_0x0", 1'b0, 1'b0, 4'h0);
    rd(32'h3C);  step(); chk_pred("post_clear_0x3c", 1'b0, 1'b0, 4'h0);

    // Saturation on the 3-bit counter instance: 5 not-taken, 8 taken, 4 not-taken
    sat_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0};
    // counters: 3,2,1,0,0, 1,2,3,4,5,6,7,7, 6,5,4,3
    sat_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      wr(32'h80, 4'h0, sat_t[i], 1'b0); step();
      rd(32'h80); wr(32'h3C, 4'h0, 1'b0, 1'b1); step();
      chk($sformatf("sat3_hit_%0d", i), {31'd0, hit3}, 32'd1);
      chk($sformatf("sat3_taken_%0d", i), {31'd0, taken3}, {31'd0, sat_e[i]});
    end

    // Reset asserted mid-clear aborts it and empties the table
    clr = 1'b1; step();
    step(); step();
    chk("midclear_busy", {31'd0, busy3}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy3}, 32'd0);
    chk("async_reset_hit", {31'd0, hit3}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #6;
    rd(32'h80); step();
    chk("after_reset_read_hit", {31'd0, hit3}, 32'd0);
    chk("after_reset_busy", {31'd0, busy3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
